// File: rtl/alu_mem_issue.sv
// alu_mem_issue
//   Issue stage in front of the alu_mem datapath. Instruction words arrive on a
//   valid/ready handshake and are buffered in a DEPTH-entry FIFO. Every cycle the
//   registered outputs carry either the decoded FIFO head (issue_valid=1) or the
//   canonical NOP (rs1=rs2=rd=imm=0, mode=1). alu_mem writes mem[rd] every edge,
//   and the NOP's mem[0]^0 leaves memory unchanged.
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   in_valid/in_ready upstream handshake; in_instr = {mode, rd, rs1, rs2, imm}
//   stall             hold the FIFO head and issue NOP
//   flush             drop all buffered words (and any same-cycle accept)
//   rs1/rs2/rd/imm/mode  registered decoded fields to alu_mem
//   issue_valid       outputs hold a real instruction
//   issued_count      real issues since reset, wraps at 2^CNT_W
//   fifo_level        current occupancy
//
// Optional feature, macro ALU_MEM_ISSUE_TAINT_EN:
//   in_taint[4:0] = {mode, rd, rs1, rs2, imm} field taints, buffered with each
//   word; rs1_t/rs2_t/rd_t/imm_t/mode_t follow a real issue and are 0 otherwise.

module alu_mem_issue #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [20:0]                in_instr,
`ifdef ALU_MEM_ISSUE_TAINT_EN
  input  logic [4:0]                 in_taint,
  output logic                       rs1_t,
  output logic                       rs2_t,
  output logic                       rd_t,
  output logic                       imm_t,
  output logic                       mode_t,
`endif
  input  logic                       stall,
  input  logic                       flush,
  output logic [3:0]                 rs1,
  output logic [3:0]                 rs2,
  output logic [3:0]                 rd,
  output logic [7:0]                 imm,
  output logic                       mode,
  output logic                       issue_valid,
  output logic [CNT_W-1:0]           issued_count,
  output logic [$clog2(DEPTH):0]     fifo_level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [20:0]   mem_instr [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [20:0]   head;
  logic          push;
  logic          pop;

`ifdef ALU_MEM_ISSUE_TAINT_EN
  logic [4:0]    mem_taint [DEPTH];
  logic [4:0]    head_taint;
  assign head_taint = mem_taint[rd_ptr];
`endif

  assign head     = mem_instr[rd_ptr];
  // Full is judged on the registered level only, so a full FIFO refuses even
  // while it pops this cycle.
  assign in_ready = !rst && (fifo_level != LW'(DEPTH));
  assign push     = in_valid && in_ready;
  assign pop      = (fifo_level != '0) && !stall && !flush;

  // Storage needs no reset; an accept coinciding with flush is dropped.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem_instr[wr_ptr] <= in_instr;
`ifdef ALU_MEM_ISSUE_TAINT_EN
      mem_taint[wr_ptr] <= in_taint;
`endif
    end
  end

  always_ff @(posedge clk) begin
    // NOP unless a real pop below overrides it.
    rs1         <= 4'd0;
    rs2         <= 4'd0;
    rd          <= 4'd0;
    imm         <= 8'd0;
    mode        <= 1'b1;
    issue_valid <= 1'b0;
`ifdef ALU_MEM_ISSUE_TAINT_EN
    {mode_t, rd_t, rs1_t, rs2_t, imm_t} <= 5'd0;
`endif
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_level   <= '0;
      issued_count <= '0;
    end else if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) begin
        rd_ptr                      <= rd_ptr + PW'(1);
        {mode, rd, rs1, rs2, imm}   <= head;
        issue_valid                 <= 1'b1;
        issued_count                <= issued_count + CNT_W'(1);
`ifdef ALU_MEM_ISSUE_TAINT_EN
        {mode_t, rd_t, rs1_t, rs2_t, imm_t} <= head_taint;
`endif
      end
      if (push && !pop)      fifo_level <= fifo_level + LW'(1);
      else if (!push && pop) fifo_level <= fifo_level - LW'(1);
    end
  end

endmodule

// File: tb/tb_alu_mem_issue.sv
// Directed bench for alu_mem_issue: hand-written words and expected outputs.
// Uses CNT_W=4 so the issued_count wrap is reachable quickly.

module tb_alu_mem_issue;

  localparam int DEPTH = 4;
  localparam int CNT_W = 4;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, stall, flush;
  logic [20:0] in_instr;
  logic [3:0]  rs1, rs2, rd;
  logic [7:0]  imm;
  logic        mode, issue_valid;
  logic [CNT_W-1:0] issued_count;
  logic [2:0]  fifo_level;
`ifdef ALU_MEM_ISSUE_TAINT_EN
  logic [4:0]  in_taint;
  logic        rs1_t, rs2_t, rd_t, imm_t, mode_t;
`endif

  int vectors = 0;
  int miscompares = 0;

  alu_mem_issue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr),
`ifdef ALU_MEM_ISSUE_TAINT_EN
    .in_taint(in_taint), .rs1_t(rs1_t), .rs2_t(rs2_t), .rd_t(rd_t),
    .imm_t(imm_t), .mode_t(mode_t),
`endif
    .stall(stall), .flush(flush), .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm),
    .mode(mode), .issue_valid(issue_valid), .issued_count(issued_count),
    .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [20:0] outs();
    return {mode, rd, rs1, rs2, imm};
  endfunction

  localparam logic [20:0] NOP_W = 21'h100000;

  // {mode, rd, rs1, rs2, imm}; W1 has rd==rs1, W2 has rs1==rs2,
  // W3 decodes to NOP fields but is a real instruction.
  logic [20:0] burst [4] = '{21'h015903, 21'h1AA3FF, 21'h0F7780, 21'h100000};
  logic [20:0] strm  [6] = '{21'h031200, 21'h1E2111, 21'h0C5422, 21'h16D833,
                             21'h09AB44, 21'h1FFFFF};

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_instr = '0; stall = 1'b0; flush = 1'b0;
`ifdef ALU_MEM_ISSUE_TAINT_EN
    in_taint = '0;
`endif
    step();
    step();
    check("rst_in_ready", in_ready, 0);
    check("rst_level", fifo_level, 0);
    check("rst_valid", issue_valid, 0);
    check("rst_outs", outs(), NOP_W);
    check("rst_count", issued_count, 0);
    rst = 1'b0;
    step();
    check("idle_in_ready", in_ready, 1);

    // single word: accepted at N, visible after N+1
    in_valid = 1'b1; in_instr = 21'h12345A;
    step();
    check("single_lvl_N", fifo_level, 1);
    check("single_nobypass", issue_valid, 0);
    in_valid = 1'b0;
    step();
    check("single_outs", outs(), 21'h12345A);
    check("single_rd", rd, 4'd2);
    check("single_imm", imm, 8'h5A);
    check("single_valid", issue_valid, 1);
    check("single_count", issued_count, 1);
    step();
    check("single_nop", outs(), NOP_W);
    check("single_nop_v", issue_valid, 0);

    // stall while filling to full
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_instr = burst[i];
      step();
      check("stall_nop", issue_valid, 0);
    end
    check("full_level", fifo_level, 4);
    check("full_ready", in_ready, 0);
    in_instr = 21'h0ABCDE;
    step();
    check("full_refuse", fifo_level, 4);
    check("full_stall_out", outs(), NOP_W);
    in_valid = 1'b0; stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("burst_word", outs(), burst[i]);
      check("burst_valid", issue_valid, 1);
      check("burst_level", fifo_level, 3 - i);
      check("burst_ready", in_ready, 1);
    end
    step();
    check("burst_end_v", issue_valid, 0);
    check("burst_count", issued_count, 5);

    // streaming: one issue per cycle at level 1
    in_valid = 1'b1; in_instr = strm[0];
    step();
    check("strm_lvl0", fifo_level, 1);
    for (int i = 1; i < 6; i++) begin
      in_instr = strm[i];
      step();
      check("strm_word", outs(), strm[i-1]);
      check("strm_lvl", fifo_level, 1);
      check("strm_count", issued_count, 5 + i);
    end
    in_valid = 1'b0;
    step();
    check("strm_last", outs(), strm[5]);
    check("strm_count_end", issued_count, 11);
    check("strm_lvl_end", fifo_level, 0);

    // flush (with stall held) drops buffer and the same-cycle offer
    stall = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_instr = burst[i];
      step();
    end
    check("pre_flush_lvl", fifo_level, 3);
    flush = 1'b1; in_instr = 21'h0DEAD1;
    check("flush_ready_may_be_1", in_ready, 1);
    step();
    check("flush_lvl", fifo_level, 0);
    check("flush_outs", outs(), NOP_W);
    flush = 1'b0; stall = 1'b0; in_valid = 1'b0;
    step();
    check("flush_drop_v", issue_valid, 0);
    check("flush_drop_lvl", fifo_level, 0);
    check("flush_count", issued_count, 11);

    // reset mid-stream
    stall = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_instr = strm[i];
      step();
    end
    check("pre_rst_lvl", fifo_level, 2);
    stall = 1'b0; rst = 1'b1;
    #1;
    check("rst_mid_ready", in_ready, 0);
    step();
    check("rst_mid_lvl", fifo_level, 0);
    check("rst_mid_count", issued_count, 0);
    check("rst_mid_outs", outs(), NOP_W);
    check("rst_mid_v", issue_valid, 0);
    rst = 1'b0; in_valid = 1'b0;
    step();
    check("post_rst_v", issue_valid, 0);
    check("post_rst_lvl", fifo_level, 0);

    // issued_count wraps modulo 16: 17 issues -> 1
    in_valid = 1'b1; in_instr = 21'h011111;
    for (int i = 0; i < 17; i++) step();
    in_valid = 1'b0;
    step();
    check("wrap_count", issued_count, 1);
    step();

`ifdef ALU_MEM_ISSUE_TAINT_EN
    in_valid = 1'b1; in_instr = 21'h012345; in_taint = 5'b00101;
    step();
    in_instr = 21'h154321; in_taint = 5'b00000;
    step();
    in_valid = 1'b0;
    check("taint_A", {mode_t, rd_t, rs1_t, rs2_t, imm_t}, 5'b00101);
    check("taint_A_rs1", rs1_t, 1);
    step();
    check("taint_B", {mode_t, rd_t, rs1_t, rs2_t, imm_t}, 5'b00000);
    check("taint_B_v", issue_valid, 1);
    step();
    check("taint_idle", {mode_t, rd_t, rs1_t, rs2_t, imm_t}, 5'b00000);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
